mult_seq_arb: RTL
=================

MULT_SEQ_ARB -- requirements
Module: mult_seq_arb

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal values 2..16.
REQ-002 Clock  input  1  rising-edge clock; single clock domain.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 multiply request, level.
REQ-005 A0, B0  input  WIDTH each  requester 0 operands (multiplicand, multiplier).
REQ-006 req1  input  1  requester 1 multiply request, level.
REQ-007 A1, B1  input  WIDTH each  requester 1 operands.
REQ-008 gnt0, gnt1  output  1 each  registered one-cycle grant pulse: operands captured.
REQ-009 busy  output  1  high while the engine is not IDLE.
REQ-010 done  output  1  registered one-cycle pulse: P valid.
REQ-011 done_id  output  1  requester index (0/1) owning the current result.
REQ-012 P  output  2*WIDTH  unsigned product; held until the next done.

Function
REQ-013 Engine SHALL be a shift-add multiplier, one partial-product add per clock, sharing one WIDTH-bit adder with carry-out.
REQ-014 FSM states SHALL be IDLE, CALC, DONE; unused encodings SHALL go to IDLE.
REQ-015 IDLE: on an edge with req0 or req1 high, SHALL capture the selected A/B, clear the accumulator and count, go to CALC, and pulse that requester's gnt in the following cycle.
REQ-016 IDLE with no request SHALL remain in IDLE; gnt0, gnt1 and done SHALL stay low.
REQ-017 Arbitration SHALL be round-robin: with both requesting, grant the requester not served last. Single requester wins regardless of pointer.
REQ-018 CALC SHALL last exactly WIDTH cycles. Each cycle: if the multiplier LSB is 1, upper half += multiplicand (carry kept); then {carry, acc} shifts right one bit and the multiplier shifts right one bit.
REQ-019 After the WIDTH-th CALC cycle, SHALL enter DONE for one cycle with done=1, P=A*B exact (no truncation), done_id=granted index.
REQ-020 DONE SHALL always return to IDLE. Latency: gnt high in cycle T+1, done high in cycle T+1+WIDTH, where T is the accepting edge.
REQ-021 Requests are not accepted in CALC or DONE. A req held high through DONE SHALL be re-arbitrated in IDLE as a new request.
REQ-022 Requesters SHALL hold req and operands stable until gnt. Operand changes after capture SHALL NOT affect P.
REQ-023 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-024 Zero operand SHALL still take the full WIDTH cycles and produce P=0.

Reset
REQ-025 Reset high SHALL immediately force: state=IDLE, gnt0=gnt1=0, done=0, busy=0, done_id=0, P=0, accumulator/count=0, round-robin pointer = "last served 1".
REQ-026 Reset mid-CALC SHALL abort the operation with no done pulse. The first grant after reset release SHALL follow REQ-017 from the reset pointer.

Structure
REQ-027 State encodings and the default WIDTH SHALL live in a shared include file, mult_defs.vh, for reuse by the display/top-level blocks.
REQ-028 The datapath adder SHALL be the team's existing parameterised adder module (A, B, ci, S, co), instantiated once with WIDTH=WIDTH and ci tied 0.
REQ-029 Control (FSM, counter, arbiter) and datapath registers SHALL reside in mult_seq_arb; target size 120-400 lines.

Verification (WIDTH=4)
REQ-030 req0=1, A0=15, B0=15 -> gnt0 next cycle; done 4 cycles later; P=8'hE1; done_id=0.
REQ-031 req0=req1=1 (A0=13, B0=11; A1=3, B1=0), both held -> gnt0 first: P=8'h8F, done_id=0. Then gnt1: P=8'h00, done_id=1. gnt never simultaneous.
REQ-032 Only req1 high, then only req1 again back-to-back -> req1 granted twice; one IDLE cycle between DONE and the next gnt.
REQ-033 Reset asserted in the 2nd CALC cycle -> all outputs 0 immediately; no done pulse. Post-release request (A0=2, B0=7) -> P=8'h0E.
REQ-034 A0/B0 changed the cycle after gnt0 -> P reflects the captured values only.
REQ-035 Exhaustive sweep of A, B in 0..15 via requester 0 -> every P equals A*B at a fixed latency of 4 cycles from gnt.

Source files
------------

// File: rtl/mult_seq_arb_pkg.sv
// Shared definitions for the sequential multiplier with two-requester
// arbitration: default operand width, FSM state encodings and the
// round-robin selection helper.
package mult_seq_arb_pkg;

    // Default operand width; legal range is 2..16.
    localparam int DEFAULT_WIDTH = 4;

    // Engine states. The fourth 2-bit encoding is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Round-robin pick: returns 1 when requester 1 should be granted.
    // A lone requester always wins. With both requesting, the one that
    // was not served last wins.
    function automatic logic rr_pick1(input logic r0, input logic r1,
                                      input logic last_served);
        return r1 & (~r0 | ~last_served);
    endfunction

endpackage

// File: rtl/mult_seq_arb_adder.sv
// Parameterised ripple adder with carry-in and carry-out. Used once by the
// multiplier datapath for the per-cycle partial-product add.
module mult_seq_arb_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ci,
    output logic [WIDTH-1:0] S,
    output logic             co
);

    logic [WIDTH:0] full;

    // Single wide add; the top bit becomes the carry-out.
    always_comb begin
        full = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, ci};
        S    = full[WIDTH-1:0];
        co   = full[WIDTH];
    end

endmodule

// File: rtl/mult_seq_arb.sv
// Shift-add multiplier shared by two requesters through a round-robin
// arbiter. One partial-product add per clock; WIDTH CALC cycles per product.
//
// Handshake: req0/req1 are level requests. A requester raises req with its
// operands valid and holds both stable until it sees its one-cycle gnt
// pulse, which means the operands were captured on the previous edge.
// Requests are only sampled while IDLE. The result is announced by a
// one-cycle done pulse; P and done_id stay valid until the next done.
module mult_seq_arb
    import mult_seq_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [WIDTH-1:0]   A0,
    input  logic [WIDTH-1:0]   B0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   A1,
    input  logic [WIDTH-1:0]   B1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [2*WIDTH-1:0] P,
    output logic [1:0]         dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;
    logic                 last_served;
    logic                 owner;

    logic [WIDTH-1:0]     sum;
    logic                 co;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 any_req;
    logic                 pick1;

    assign dbg_state = state;

    // Upper accumulator half plus multiplicand; carry kept for the shift.
    mult_seq_arb_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .A  (acc[2*WIDTH-1:WIDTH]),
        .B  (mcand),
        .ci (1'b0),
        .S  (sum),
        .co (co)
    );

    // Next accumulator: conditional add, then {carry, acc} shifted right.
    always_comb begin
        if (mplier[0])
            acc_next = {co, sum, acc[WIDTH-1:1]};
        else
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end

    // Arbiter decision, only acted upon while IDLE.
    always_comb begin
        any_req = req0 | req1;
        pick1   = rr_pick1(req0, req1, last_served);
    end

    // Control FSM with registered grant/done outputs and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            done_id     <= 1'b0;
            P           <= '0;
            acc         <= '0;
            count       <= '0;
            mcand       <= '0;
            mplier      <= '0;
            owner       <= 1'b0;
            last_served <= 1'b1;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        mcand       <= pick1 ? A1 : A0;
                        mplier      <= pick1 ? B1 : B0;
                        acc         <= '0;
                        count       <= '0;
                        owner       <= pick1;
                        last_served <= pick1;
                        gnt0        <= ~pick1;
                        gnt1        <= pick1;
                        busy        <= 1'b1;
                        state       <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == LAST_STEP) begin
                        // Final step: publish the completed product directly.
                        P       <= acc_next;
                        done    <= 1'b1;
                        done_id <= owner;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
